// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the request/grant handshake and memory-port control signals that
//   pass between the three masters (instruction fetch, load/store, debug/DMA),
//   the arbiter and the memory interface.
//
//   Signals
//     req          [2:0]  request per requester, held high until served
//     mem_ack             memory transaction complete, 1-cycle pulse
//     grant        [2:0]  one-hot grant, all zero = no owner
//     sel          [1:0]  address/data mux select = current/last owner index
//     mem_req             request to memory, high throughout a transaction
//     busy                high while a transaction is in progress
//     timeout_err         1-cycle pulse on watchdog abort
//
//   Modports
//     master : the arbiter, which owns the memory port and drives grant/sel
//     slave  : the surrounding system (requesters and memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic [2:0] req;
  logic       mem_ack;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       mem_req;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  req, mem_ack,
    output grant, sel, mem_req, busy, timeout_err
  );

  modport slave (
    output req, mem_ack,
    input  grant, sel, mem_req, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter sharing one memory port between three requesters
//   (0 = instruction fetch, 1 = data load/store, 2 = debug/DMA). A grant is
//   held for a whole memory transaction; sel drives the 3:1 address/data mux
//   in front of the memory port and keeps the last owner between grants.
//
//   Ports
//     clk   in  system clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   mem_port_arbiter_if.master (req, mem_ack in; grant, sel,
//           mem_req, busy, timeout_err out; all outputs registered)
//
//   Parameters
//     TIMEOUT  max BUSY cycles without ack before abort (>= 2)
//     CNT_W    timeout counter width, must hold TIMEOUT-1
//
//   Optional feature
//     ARB_TIMEOUT_EN  when defined, a watchdog aborts a transaction after
//                     TIMEOUT BUSY cycles without mem_ack and pulses
//                     timeout_err. When undefined, timeout_err is tied low
//                     and BUSY waits for mem_ack indefinitely.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg;
  logic [1:0] last_reg;
  logic [1:0] sel_reg;
  logic [2:0] grant_reg;
  logic       mem_req_reg;
  logic       busy_reg;

  // Round-robin scan order: candidate gi is (last + 1 + gi) mod 3, so the
  // previous owner is considered last.
  logic [2:0] sum  [3];
  logic [1:0] cand [3];
  logic [2:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_scan
      assign sum[gi]  = {1'b0, last_reg} + 3'(gi + 1);
      assign cand[gi] = (sum[gi] >= 3'd3) ? 2'(sum[gi] - 3'd3) : sum[gi][1:0];
      assign hit[gi]  = bus.req[cand[gi]];
    end
  endgenerate

  logic       any_req;
  logic [1:0] pick_idx;

  assign any_req = |hit;

  always_comb begin
    pick_idx = sel_reg;
    if (hit[0])      pick_idx = cand[0];
    else if (hit[1]) pick_idx = cand[1];
    else if (hit[2]) pick_idx = cand[2];
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_err_reg;
  logic             terminal;

  assign terminal = (cnt_reg == CNT_W'(TIMEOUT - 1));
`else
  // Keeps the watchdog parameters referenced when the feature is compiled out.
  localparam int timeout_unused = TIMEOUT + CNT_W;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 2'd2;   // requester 0 wins the first arbitration
      sel_reg     <= 2'd0;
      grant_reg   <= 3'b000;
      mem_req_reg <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // mem_ack is ignored here; with no request, sel keeps the last owner
          if (any_req) begin
            grant_reg   <= 3'b001 << pick_idx;
            sel_reg     <= pick_idx;
            mem_req_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_reg     <= '0;
`endif
          end
        end
        BUSY: begin
          // req changes (owner or others) are ignored until back in IDLE.
          // sel_reg holds the owner index throughout and is left unchanged.
          if (bus.mem_ack) begin
            grant_reg   <= 3'b000;
            mem_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            last_reg    <= sel_reg;
            state_reg   <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          // Ack has priority over a simultaneous terminal count.
          else if (terminal) begin
            grant_reg       <= 3'b000;
            mem_req_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            last_reg        <= sel_reg;
            state_reg       <= IDLE;
            timeout_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_reg;
  assign bus.sel     = sel_reg;
  assign bus.mem_req = mem_req_reg;
  assign bus.busy    = busy_reg;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_reg;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table-driven vectors plus hand-written
// watchdog / long-transaction sequences. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, after the edge that
// consumed the previous inputs.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (8),
    .CNT_W   (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] req;
    logic       ack;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       mem_req;
    logic       busy;
    logic       terr;
  } vec_t;

  vec_t vq[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic add(input string name, input logic r, input logic [2:0] rq,
                     input logic a, input logic [2:0] g, input logic [1:0] s,
                     input logic mr, input logic b, input logic te);
    vec_t v;
    v.name = name; v.rst = r; v.req = rq; v.ack = a;
    v.grant = g; v.sel = s; v.mem_req = mr; v.busy = b; v.terr = te;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.grant, bus.sel, bus.mem_req, bus.busy, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: grant/sel/mreq/busy/terr=%b", name, act);
    end else begin
      $display("FAIL %s: got grant/sel/mreq/busy/terr=%b expected %b",
               name, act, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = 3'b000;
    bus.mem_ack = 1'b0;

    //   name        rst req   ack grant  sel  mr b  te
    add("reset",      1, 3'b000, 0, 3'b000, 2'd0, 0, 0, 0);
    // 1: req=111 held, ack two cycles after each grant
    add("rr_g0",      0, 3'b111, 0, 3'b001, 2'd0, 1, 1, 0);
    add("rr_h0",      0, 3'b111, 0, 3'b001, 2'd0, 1, 1, 0);
    add("rr_a0",      0, 3'b111, 1, 3'b000, 2'd0, 0, 0, 0);
    add("rr_g1",      0, 3'b111, 0, 3'b010, 2'd1, 1, 1, 0);
    add("rr_h1",      0, 3'b111, 0, 3'b010, 2'd1, 1, 1, 0);
    add("rr_a1",      0, 3'b111, 1, 3'b000, 2'd1, 0, 0, 0);
    add("rr_g2",      0, 3'b111, 0, 3'b100, 2'd2, 1, 1, 0);
    add("rr_h2",      0, 3'b111, 0, 3'b100, 2'd2, 1, 1, 0);
    add("rr_a2",      0, 3'b111, 1, 3'b000, 2'd2, 0, 0, 0);
    add("rr_g0b",     0, 3'b111, 0, 3'b001, 2'd0, 1, 1, 0);
    add("rr_a0b",     0, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0);
    // 2: single requester 1, ack three edges after grant edge
    add("s1_g",       0, 3'b010, 0, 3'b010, 2'd1, 1, 1, 0);
    add("s1_h1",      0, 3'b010, 0, 3'b010, 2'd1, 1, 1, 0);
    add("s1_h2",      0, 3'b010, 0, 3'b010, 2'd1, 1, 1, 0);
    add("s1_ack",     0, 3'b010, 1, 3'b000, 2'd1, 0, 0, 0);
    add("s1_idle",    0, 3'b000, 0, 3'b000, 2'd1, 0, 0, 0);
    // 3: req=101, immediate ack, owners alternate 2,0,2,0
    add("alt_g2",     0, 3'b101, 0, 3'b100, 2'd2, 1, 1, 0);
    add("alt_a2",     0, 3'b101, 1, 3'b000, 2'd2, 0, 0, 0);
    add("alt_g0",     0, 3'b101, 0, 3'b001, 2'd0, 1, 1, 0);
    add("alt_a0",     0, 3'b101, 1, 3'b000, 2'd0, 0, 0, 0);
    add("alt_g2b",    0, 3'b101, 0, 3'b100, 2'd2, 1, 1, 0);
    add("alt_a2b",    0, 3'b101, 1, 3'b000, 2'd2, 0, 0, 0);
    add("alt_g0b",    0, 3'b101, 0, 3'b001, 2'd0, 1, 1, 0);
    add("alt_a0b",    0, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0);
    // 6: ack while idle ignored; owner/non-owner req changes ignored in BUSY
    add("idle_ack1",  0, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0);
    add("idle_ack2",  0, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0);
    add("drop_g1",    0, 3'b010, 0, 3'b010, 2'd1, 1, 1, 0);
    add("drop_own",   0, 3'b000, 0, 3'b010, 2'd1, 1, 1, 0);
    add("drop_oth",   0, 3'b101, 0, 3'b010, 2'd1, 1, 1, 0);
    add("drop_ack",   0, 3'b000, 1, 3'b000, 2'd1, 0, 0, 0);
    add("drop_idle",  0, 3'b000, 0, 3'b000, 2'd1, 0, 0, 0);
    // 5: reset during BUSY of requester 2, then requester 0 wins
    add("mr_g2",      0, 3'b100, 0, 3'b100, 2'd2, 1, 1, 0);
    add("mr_h2",      0, 3'b100, 0, 3'b100, 2'd2, 1, 1, 0);
    add("mr_rst",     1, 3'b100, 1, 3'b000, 2'd0, 0, 0, 0);
    add("mr_g0",      0, 3'b111, 0, 3'b001, 2'd0, 1, 1, 0);
    add("mr_a0",      0, 3'b000, 1, 3'b000, 2'd0, 0, 0, 0);

    #2;
    foreach (vq[i]) begin
      rst         = vq[i].rst;
      bus.req     = vq[i].req;
      bus.mem_ack = vq[i].ack;
      step();
      check(vq[i].name, outs(),
            {vq[i].grant, vq[i].sel, vq[i].mem_req, vq[i].busy, vq[i].terr});
    end
    rst         = 1'b0;
    bus.req     = 3'b000;
    bus.mem_ack = 1'b0;

    // Last owner is 0, so a lone request from 0 is granted next.
`ifdef ARB_TIMEOUT_EN
    // Watchdog abort: BUSY lasts 8 cycles with no ack.
    bus.req = 3'b001;
    step();
    check("to_grant", outs(), 8'b001_00_1_1_0);
    bus.req = 3'b000;
    for (int k = 1; k < 8; k++) step();
    check("to_cycle8", outs(), 8'b001_00_1_1_0);
    step();
    check("to_abort", outs(), 8'b000_00_0_0_1);
    step();
    check("to_pulse_end", outs(), 8'b000_00_0_0_0);

    // Ack on the terminal cycle wins: no error.
    bus.req = 3'b001;
    step();
    check("tack_grant", outs(), 8'b001_00_1_1_0);
    bus.req = 3'b000;
    for (int k = 1; k < 8; k++) step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("tack_done", outs(), 8'b000_00_0_0_0);
    step();
    check("tack_quiet", outs(), 8'b000_00_0_0_0);
`else
    // No watchdog: grant held well beyond any timeout.
    bus.req = 3'b001;
    step();
    check("hold_grant", outs(), 8'b001_00_1_1_0);
    bus.req = 3'b000;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 7 || k == 8 || k == 23)
        check($sformatf("hold_c%0d", k + 2), outs(), 8'b001_00_1_1_0);
    end
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    check("hold_ack", outs(), 8'b000_00_0_0_0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
